// File: rtl/pio_latency_timer_pkg.sv
// Shared constants for the multi-channel HPS<->FPGA latency timer:
// opcodes, response status codes, command/response field positions, FSM encoding.
package pio_timer_pkg;

    localparam logic [2:0] OP_START = 3'd1;
    localparam logic [2:0] OP_STOP  = 3'd2;
    localparam logic [2:0] OP_READ  = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;

    localparam logic [2:0] ST_OK              = 3'd0;
    localparam logic [2:0] ST_SAT             = 3'd1;
    localparam logic [2:0] ST_ALREADY_RUNNING = 3'd2;
    localparam logic [2:0] ST_NOT_RUNNING     = 3'd3;
    localparam logic [2:0] ST_BAD_CH          = 3'd4;
    localparam logic [2:0] ST_BAD_OP          = 3'd5;

    // Bit positions shared by the command and response words
    localparam int unsigned F_TOG   = 31;
    localparam int unsigned F_OP_HI = 30;
    localparam int unsigned F_OP_LO = 28;
    localparam int unsigned F_CH_HI = 27;
    localparam int unsigned F_CH_LO = 24;
    localparam int unsigned F_VAL_W = 24;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EXEC = 1'b1;

endpackage

// File: rtl/pio_latency_timer_if.sv
// PIO-side bundle of the latency timer: command word in, response word and
// per-channel status flags out.
interface pio_latency_timer_if #(
    parameter int unsigned NUM_CH = 4
);
    logic [31:0]       cmd_i;
    logic [31:0]       rsp_o;
    logic [NUM_CH-1:0] running_o;
    logic [NUM_CH-1:0] sat_o;

    modport master (output cmd_i, input rsp_o, input running_o, input sat_o);
    modport slave  (input cmd_i, output rsp_o, output running_o, output sat_o);
endinterface

// File: rtl/pio_latency_timer_ch.sv
// One timer channel: saturating up-counter with running and saturated flags,
// controlled by single-cycle start/stop/clear strobes from the command FSM.
module pio_timer_ch #(
    parameter int unsigned CNT_W = 24
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count,
    output logic             o_running,
    output logic             o_sat
);
    logic [CNT_W-1:0] r_count;
    logic             r_running;
    logic             r_sat;

    // Strobes take priority over the increment so a command always wins its cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count   <= '0;
            r_running <= 1'b0;
            r_sat     <= 1'b0;
        end else if (i_clear) begin
            r_count   <= '0;
            r_running <= 1'b0;
            r_sat     <= 1'b0;
        end else if (i_start) begin
            r_count   <= '0;
            r_running <= 1'b1;
            r_sat     <= 1'b0;
        end else if (i_stop) begin
            r_running <= 1'b0;
        end else if (r_running) begin
            if (r_count == '1) begin
                r_sat <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_count   = r_count;
    assign o_running = r_running;
    assign o_sat     = r_sat;

endmodule

// File: rtl/pio_latency_timer.sv
// Multi-channel latency timer: toggle-handshaked command latch, two-state
// IDLE/EXEC FSM, channel mux and registered tagged response.
module pio_latency_timer
    import pio_timer_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 24
) (
    input  logic CLOCK_50,
    input  logic reset_n,
    pio_latency_timer_if.slave pio
);
    logic [0:0]       r_state;
    logic             r_last_tog;
    logic [31:24]     r_cmd_q;
    logic [31:0]      r_rsp;

    logic [2:0]       w_op;
    logic [3:0]       w_ch;
    logic             w_ch_ok;
    logic             w_exec;
    logic [CNT_W-1:0] w_cnt [NUM_CH];
    logic [NUM_CH-1:0] w_run;
    logic [NUM_CH-1:0] w_sat;
    logic [NUM_CH-1:0] w_hit;
    logic [NUM_CH-1:0] w_start;
    logic [NUM_CH-1:0] w_stop;
    logic [NUM_CH-1:0] w_clear;
    logic [CNT_W-1:0] w_sel_cnt;
    logic             w_sel_run;
    logic             w_sel_sat;
    logic [2:0]       w_status;
    logic [F_VAL_W-1:0] w_val;
    logic             w_unused_cmd;

    assign w_op         = r_cmd_q[F_OP_HI:F_OP_LO];
    assign w_ch         = r_cmd_q[F_CH_HI:F_CH_LO];
    assign w_ch_ok      = 32'(w_ch) < NUM_CH;
    assign w_exec       = (r_state == S_EXEC);
    assign w_unused_cmd = ^pio.cmd_i[23:0];

    // Select the addressed channel and build its one-hot strobe mask
    always_comb begin
        w_sel_cnt = '0;
        w_sel_run = 1'b0;
        w_sel_sat = 1'b0;
        w_hit     = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(w_ch) == i) begin
                w_sel_cnt = w_cnt[i];
                w_sel_run = w_run[i];
                w_sel_sat = w_sat[i];
                w_hit[i]  = 1'b1;
            end
        end
    end

    // Decode the latched command into channel strobes, status and value
    always_comb begin
        w_status = ST_OK;
        w_val    = '0;
        w_start  = '0;
        w_stop   = '0;
        w_clear  = '0;
        if (!w_ch_ok) begin
            w_status = ST_BAD_CH;
        end else begin
            case (w_op)
                OP_START: begin
                    if (w_sel_run) begin
                        w_status             = ST_ALREADY_RUNNING;
                        w_val[CNT_W-1:0]     = w_sel_cnt;
                    end else begin
                        w_start = w_exec ? w_hit : '0;
                    end
                end
                OP_STOP: begin
                    w_val[CNT_W-1:0] = w_sel_cnt;
                    if (w_sel_run) begin
                        w_status = w_sel_sat ? ST_SAT : ST_OK;
                        w_stop   = w_exec ? w_hit : '0;
                    end else begin
                        w_status = ST_NOT_RUNNING;
                    end
                end
                OP_READ: begin
                    w_val[CNT_W-1:0] = w_sel_cnt;
                    w_status         = w_sel_sat ? ST_SAT : ST_OK;
                end
                OP_CLEAR: begin
                    w_clear = w_exec ? w_hit : '0;
                end
                default: begin
                    w_status = ST_BAD_OP;
                end
            endcase
        end
    end

    // Handshake FSM: latch on toggle change, execute and respond one clock later
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_last_tog <= 1'b0;
            r_cmd_q    <= '0;
            r_rsp      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (pio.cmd_i[F_TOG] != r_last_tog) begin
                        r_cmd_q <= pio.cmd_i[31:24];
                        r_state <= S_EXEC;
                    end
                end
                default: begin
                    r_rsp      <= {r_cmd_q[F_TOG], w_status, w_ch, w_val};
                    r_last_tog <= r_cmd_q[F_TOG];
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pio_timer_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .i_clk     (CLOCK_50),
            .i_rst_n   (reset_n),
            .i_start   (w_start[g]),
            .i_stop    (w_stop[g]),
            .i_clear   (w_clear[g]),
            .o_count   (w_cnt[g]),
            .o_running (w_run[g]),
            .o_sat     (w_sat[g])
        );
    end

    assign pio.rsp_o     = r_rsp;
    assign pio.running_o = w_run;
    assign pio.sat_o     = w_sat;

endmodule

// File: tb/tb_pio_latency_timer.sv
// Directed bench for pio_latency_timer. Instance A (NUM_CH=4, CNT_W=24) covers
// timing, errors, handshake and reset; instance B (CNT_W=4) covers saturation.
// Stimulus is always driven just after a falling edge; a channel started at
// rising edge S reads S'-S-1 at the response edge S' (pre-increment value).
module tb_pio_latency_timer;
    import pio_timer_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic tog_a = 1'b0;
    logic tog_b = 1'b0;
    logic [31:0] rsp;
    int   rsp_cyc;

    always #5 clk = ~clk;

    // Rising-edge counter used to timestamp responses
    always @(posedge clk) cyc <= cyc + 1;

    pio_latency_timer_if #(.NUM_CH(4)) ifa ();
    pio_latency_timer_if #(.NUM_CH(4)) ifb ();

    pio_latency_timer #(.NUM_CH(4), .CNT_W(24)) dut_a (
        .CLOCK_50 (clk),
        .reset_n  (rst_n),
        .pio      (ifa)
    );

    pio_latency_timer #(.NUM_CH(4), .CNT_W(4)) dut_b (
        .CLOCK_50 (clk),
        .reset_n  (rst_n),
        .pio      (ifb)
    );

    // Drive one command with a flipped toggle and wait (bounded) for its ack
    task automatic issue(input bit sel, input logic [2:0] op, input logic [3:0] ch);
        logic t;
        bit   seen;
        seen = 1'b0;
        if (!sel) begin
            tog_a     = ~tog_a;
            t         = tog_a;
            ifa.cmd_i = {t, op, ch, 24'h0};
        end else begin
            tog_b     = ~tog_b;
            t         = tog_b;
            ifb.cmd_i = {t, op, ch, 24'h0};
        end
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            rsp = sel ? ifb.rsp_o : ifa.rsp_o;
            if (rsp[31] === t) begin
                seen    = 1'b1;
                rsp_cyc = cyc;
            end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL ack_timeout: ack=%b want %b", rsp[31], t); end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        ifa.cmd_i = '0;
        ifb.cmd_i = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (ifa.rsp_o !== 32'h0) begin bad++; $display("FAIL rst_rsp: got %h want %h", ifa.rsp_o, 32'h0); end
        total++; if (ifa.running_o !== 4'h0) begin bad++; $display("FAIL rst_running: got %h want %h", ifa.running_o, 4'h0); end
        total++; if (ifa.sat_o !== 4'h0) begin bad++; $display("FAIL rst_sat: got %h want %h", ifa.sat_o, 4'h0); end
        total++; if (ifb.rsp_o !== 32'h0) begin bad++; $display("FAIL rst_rsp_b: got %h want %h", ifb.rsp_o, 32'h0); end
    endtask

    task automatic test_start_stop();
        int c_start;
        issue(0, OP_START, 4'd0);
        c_start = rsp_cyc;
        total++; if (rsp !== 32'h8000_0000) begin bad++; $display("FAIL ss_start: got %h want %h", rsp, 32'h8000_0000); end
        total++; if (ifa.running_o[0] !== 1'b1) begin bad++; $display("FAIL ss_run1: got %b want 1", ifa.running_o[0]); end
        repeat (100) @(negedge clk);
        issue(0, OP_STOP, 4'd0);
        total++; if (rsp_cyc - c_start !== 102) begin bad++; $display("FAIL ss_gap: got %0d want %0d", rsp_cyc - c_start, 102); end
        total++; if (rsp !== 32'h0000_0065) begin bad++; $display("FAIL ss_stop: got %h want %h", rsp, 32'h0000_0065); end
        total++; if (ifa.running_o[0] !== 1'b0) begin bad++; $display("FAIL ss_run0: got %b want 0", ifa.running_o[0]); end
    endtask

    task automatic test_errors();
        issue(0, OP_STOP, 4'd2);
        total++; if (rsp !== 32'hB200_0000) begin bad++; $display("FAIL err_not_running: got %h want %h", rsp, 32'hB200_0000); end
        issue(0, OP_START, 4'd2);
        total++; if (rsp !== 32'h0200_0000) begin bad++; $display("FAIL err_start2: got %h want %h", rsp, 32'h0200_0000); end
        issue(0, OP_START, 4'd2);
        total++; if (rsp !== 32'hA200_0001) begin bad++; $display("FAIL err_already: got %h want %h", rsp, 32'hA200_0001); end
        issue(0, OP_READ, 4'd4);
        total++; if (rsp !== 32'h4400_0000) begin bad++; $display("FAIL err_bad_ch: got %h want %h", rsp, 32'h4400_0000); end
        issue(0, 3'd7, 4'd0);
        total++; if (rsp !== 32'hD000_0000) begin bad++; $display("FAIL err_bad_op: got %h want %h", rsp, 32'hD000_0000); end
        issue(0, OP_READ, 4'd0);
        total++; if (rsp !== 32'h0000_0065) begin bad++; $display("FAIL err_ch0_kept: got %h want %h", rsp, 32'h0000_0065); end
        issue(0, OP_READ, 4'd2);
        total++; if (rsp !== 32'h8200_0009) begin bad++; $display("FAIL err_ch2_count: got %h want %h", rsp, 32'h8200_0009); end
        total++; if (ifa.running_o !== 4'b0100) begin bad++; $display("FAIL err_running: got %b want %b", ifa.running_o, 4'b0100); end
        issue(0, OP_STOP, 4'd2);
        total++; if (rsp !== 32'h0200_000B) begin bad++; $display("FAIL err_stop2: got %h want %h", rsp, 32'h0200_000B); end
    endtask

    task automatic test_concurrency();
        issue(0, OP_START, 4'd0);
        total++; if (rsp !== 32'h8000_0000) begin bad++; $display("FAIL cc_start0: got %h want %h", rsp, 32'h8000_0000); end
        issue(0, OP_START, 4'd3);
        total++; if (rsp !== 32'h0300_0000) begin bad++; $display("FAIL cc_start3: got %h want %h", rsp, 32'h0300_0000); end
        total++; if (ifa.running_o !== 4'b1001) begin bad++; $display("FAIL cc_running: got %b want %b", ifa.running_o, 4'b1001); end
        repeat (50) @(negedge clk);
        issue(0, OP_STOP, 4'd3);
        total++; if (rsp !== 32'h8300_0033) begin bad++; $display("FAIL cc_stop3: got %h want %h", rsp, 32'h8300_0033); end
        repeat (80) @(negedge clk);
        issue(0, OP_STOP, 4'd0);
        total++; if (rsp !== 32'h0000_0087) begin bad++; $display("FAIL cc_stop0: got %h want %h", rsp, 32'h0000_0087); end
    endtask

    task automatic test_saturation();
        issue(1, OP_START, 4'd1);
        total++; if (rsp !== 32'h8100_0000) begin bad++; $display("FAIL sat_start: got %h want %h", rsp, 32'h8100_0000); end
        repeat (20) @(negedge clk);
        issue(1, OP_READ, 4'd1);
        total++; if (rsp !== 32'h1100_000F) begin bad++; $display("FAIL sat_read: got %h want %h", rsp, 32'h1100_000F); end
        total++; if (ifb.sat_o[1] !== 1'b1) begin bad++; $display("FAIL sat_flag: got %b want 1", ifb.sat_o[1]); end
        total++; if (ifb.running_o[1] !== 1'b1) begin bad++; $display("FAIL sat_still_run: got %b want 1", ifb.running_o[1]); end
        issue(1, OP_CLEAR, 4'd1);
        total++; if (rsp !== 32'h8100_0000) begin bad++; $display("FAIL sat_clear: got %h want %h", rsp, 32'h8100_0000); end
        total++; if (ifb.sat_o[1] !== 1'b0) begin bad++; $display("FAIL sat_cleared: got %b want 0", ifb.sat_o[1]); end
    endtask

    task automatic test_handshake();
        logic [31:0] prev;
        int          changes;
        issue(0, OP_START, 4'd1);
        total++; if (rsp !== 32'h8100_0000) begin bad++; $display("FAIL hs_start: got %h want %h", rsp, 32'h8100_0000); end
        prev    = ifa.rsp_o;
        changes = 0;
        repeat (1000) begin
            @(negedge clk);
            if (ifa.rsp_o !== prev) changes++;
            prev = ifa.rsp_o;
        end
        total++; if (changes !== 0) begin bad++; $display("FAIL hs_hold_once: got %0d extra responses want 0", changes); end
        // READ ch1 now, then flip the toggle again while it is in EXEC
        tog_a     = ~tog_a;
        ifa.cmd_i = {tog_a, OP_READ, 4'd1, 24'h0};
        @(negedge clk);
        tog_a     = ~tog_a;
        ifa.cmd_i = {tog_a, OP_STOP, 4'd1, 24'h0};
        @(negedge clk);
        total++; if (ifa.rsp_o !== 32'h0100_03E9) begin bad++; $display("FAIL hs_read: got %h want %h", ifa.rsp_o, 32'h0100_03E9); end
        @(negedge clk);
        total++; if (ifa.rsp_o !== 32'h0100_03E9) begin bad++; $display("FAIL hs_serial: got %h want %h", ifa.rsp_o, 32'h0100_03E9); end
        @(negedge clk);
        total++; if (ifa.rsp_o !== 32'h8100_03EB) begin bad++; $display("FAIL hs_second: got %h want %h", ifa.rsp_o, 32'h8100_03EB); end
        total++; if (ifa.running_o[1] !== 1'b0) begin bad++; $display("FAIL hs_stopped: got %b want 0", ifa.running_o[1]); end
    endtask

    task automatic test_reset_midrun();
        issue(0, OP_START, 4'd0);
        repeat (30) @(negedge clk);
        rst_n     = 1'b0;
        ifa.cmd_i = '0;
        ifb.cmd_i = '0;
        tog_a     = 1'b0;
        tog_b     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (ifa.rsp_o !== 32'h0) begin bad++; $display("FAIL mr_rsp: got %h want %h", ifa.rsp_o, 32'h0); end
        total++; if (ifa.running_o !== 4'h0) begin bad++; $display("FAIL mr_running: got %b want %b", ifa.running_o, 4'h0); end
        total++; if (ifa.sat_o !== 4'h0) begin bad++; $display("FAIL mr_sat: got %b want %b", ifa.sat_o, 4'h0); end
        issue(0, OP_READ, 4'd0);
        total++; if (rsp !== 32'h8000_0000) begin bad++; $display("FAIL mr_cnt0: got %h want %h", rsp, 32'h8000_0000); end
        issue(0, OP_READ, 4'd3);
        total++; if (rsp !== 32'h0300_0000) begin bad++; $display("FAIL mr_cnt3: got %h want %h", rsp, 32'h0300_0000); end
        issue(0, OP_START, 4'd0);
        total++; if (rsp !== 32'h8000_0000) begin bad++; $display("FAIL mr_restart: got %h want %h", rsp, 32'h8000_0000); end
        total++; if (ifa.running_o[0] !== 1'b1) begin bad++; $display("FAIL mr_run: got %b want 1", ifa.running_o[0]); end
        repeat (10) @(negedge clk);
        issue(0, OP_STOP, 4'd0);
        total++; if (rsp !== 32'h0000_000B) begin bad++; $display("FAIL mr_stop: got %h want %h", rsp, 32'h0000_000B); end
    endtask

    initial begin
        test_reset();
        test_start_stop();
        test_errors();
        test_concurrency();
        test_saturation();
        test_handshake();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
